// File: rtl/requant_pack_unit.sv
// requant_pack_unit
// Output stage behind the convolution units. It takes a stream of signed
// 32-bit accumulators and requantizes each one to int8 using TFLite
// semantics:
//   - Q31 fixed-point multiply with saturating rounding doubling high part
//   - rounding right shift
//   - zero-point add
//   - activation clamp
// Four int8 results are then packed into each 32-bit output word.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               job start pulse, honoured only while ready=1
//   cfg_multiplier      signed Q31 multiplier, latched on start
//   cfg_shift           right shift 0..31, latched on start
//   cfg_out_zp          signed output zero point, latched on start
//   cfg_act_min/max     signed clamp bounds, latched on start
//   acc_valid/ready     accumulator handshake (acc_data, acc_last)
//   out_valid/ready     packed word handshake (out_data, out_be, out_last)
//   ready               idle and able to take start
//   done                one-cycle pulse after the final word is taken

module requant_pack_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] cfg_multiplier,
   input  logic [4:0]  cfg_shift,
   input  logic [7:0]  cfg_out_zp,
   input  logic [7:0]  cfg_act_min,
   input  logic [7:0]  cfg_act_max,
   input  logic        acc_valid,
   input  logic [31:0] acc_data,
   input  logic        acc_last,
   output logic        acc_ready,
   output logic        out_valid,
   output logic [31:0] out_data,
   output logic [3:0]  out_be,
   output logic        out_last,
   input  logic        out_ready,
   output logic        ready,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} StateType;

   StateType           r_state;
   logic [31:0]        r_multiplier;
   logic [4:0]         r_shift;
   logic [7:0]         r_outZp;
   logic [7:0]         r_actMin;
   logic [7:0]         r_actMax;

   logic               r_s1Valid;
   logic               r_s1Last;
   logic               r_s1Sat;
   logic signed [63:0] r_s1Prod;

   logic               r_s2Valid;
   logic               r_s2Last;
   logic signed [31:0] r_s2X;

   logic [1:0]         r_lane;
   logic [31:0]        r_pack;
   logic               r_outValid;
   logic [31:0]        r_outData;
   logic [3:0]         r_outBe;
   logic               r_outLast;

   logic               w_stall;
   logic               w_accept;
   logic signed [63:0] w_prod;
   logic signed [63:0] w_nudge;
   logic signed [63:0] w_sum;
   logic signed [63:0] w_biased;
   logic signed [31:0] w_x;
   logic [31:0]        w_mask;
   logic [31:0]        w_rem;
   logic [31:0]        w_thr;
   logic signed [31:0] w_shifted;
   logic               w_roundUp;
   logic signed [31:0] w_y;
   logic signed [32:0] w_z;
   logic signed [32:0] w_minExt;
   logic signed [32:0] w_maxExt;
   logic [7:0]         w_byte;
   logic [31:0]        w_packNext;
   logic [3:0]         w_beNext;
   logic               w_emit;

   // A held output word freezes every stage so nothing is overwritten or lost.
   assign w_stall   = r_outValid && !out_ready;
   assign acc_ready = (r_state == RUN) && !w_stall;
   assign w_accept  = acc_valid && acc_ready;

   assign ready     = (r_state == IDLE);
   assign done      = (r_state == DONE);
   assign out_valid = r_outValid;
   assign out_data  = r_outData;
   assign out_be    = r_outBe;
   assign out_last  = r_outLast;

   // Full 64-bit signed product of accumulator and latched multiplier.
   assign w_prod = $signed({{32{acc_data[31]}}, acc_data})
                 * $signed({{32{r_multiplier[31]}}, r_multiplier});

   // Rounding doubling high multiply. The quotient is truncated toward zero,
   // so negative sums get a bias of 2^31-1 before the arithmetic shift.
   // Only -2^31 * -2^31 can overflow, and that case is flagged in S1.
   always_comb begin
      w_nudge  = r_s1Prod[63] ? (64'sd1 - 64'sd1073741824) : 64'sd1073741824;
      w_sum    = r_s1Prod + w_nudge;
      w_biased = w_sum[63] ? (w_sum + 64'sd2147483647) : w_sum;
      w_x      = r_s1Sat ? 32'sh7FFFFFFF : 32'(w_biased >>> 31);
   end

   // Rounding divide by 2^shift (ties away from zero), zero-point add at
   // 33 bits so it cannot wrap, then clamp into the activation range.
   always_comb begin
      w_mask    = (32'd1 << r_shift) - 32'd1;
      w_rem     = r_s2X & w_mask;
      w_thr     = (w_mask >> 1) + {31'd0, r_s2X[31]};
      w_shifted = r_s2X >>> r_shift;
      w_roundUp = (w_rem > w_thr);
      w_y       = w_shifted + {31'd0, w_roundUp};
      w_z       = {w_y[31], w_y} + {{25{r_outZp[7]}}, r_outZp};
      w_minExt  = {{25{r_actMin[7]}}, r_actMin};
      w_maxExt  = {{25{r_actMax[7]}}, r_actMax};
      if (w_z < w_minExt) begin
         w_byte = r_actMin;
      end else if (w_z > w_maxExt) begin
         w_byte = r_actMax;
      end else begin
         w_byte = w_z[7:0];
      end
   end

   // Lanes above the current one are always zero in the pack register, so
   // OR-ing the new byte in is enough. The byte enables reflect how many
   // lanes the word holds once this byte is included.
   always_comb begin
      w_packNext = r_pack | ({24'd0, w_byte} << {r_lane, 3'b000});
      w_emit     = r_s2Valid && ((r_lane == 2'd3) || r_s2Last);
      case (r_lane)
         2'd0:    w_beNext = 4'b0001;
         2'd1:    w_beNext = 4'b0011;
         2'd2:    w_beNext = 4'b0111;
         default: w_beNext = 4'b1111;
      endcase
   end

   // Job sequencing. Configuration is captured once per job on start.
   // The job ends only when the word carrying the last element is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_multiplier <= 32'd0;
         r_shift      <= 5'd0;
         r_outZp      <= 8'd0;
         r_actMin     <= 8'd0;
         r_actMax     <= 8'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state      <= RUN;
                  r_multiplier <= cfg_multiplier;
                  r_shift      <= cfg_shift;
                  r_outZp      <= cfg_out_zp;
                  r_actMin     <= cfg_act_min;
                  r_actMax     <= cfg_act_max;
               end
            end
            RUN: begin
               if (w_accept && acc_last) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (r_outValid && out_ready && r_outLast) begin
                  r_state <= DONE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Three pipeline stages: S1 product, S2 scaled value, S3 pack/output.
   // Data registers only load when their stage takes a new element.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1Valid  <= 1'b0;
         r_s1Last   <= 1'b0;
         r_s1Sat    <= 1'b0;
         r_s1Prod   <= 64'sd0;
         r_s2Valid  <= 1'b0;
         r_s2Last   <= 1'b0;
         r_s2X      <= 32'sd0;
         r_lane     <= 2'd0;
         r_pack     <= 32'd0;
         r_outValid <= 1'b0;
         r_outData  <= 32'd0;
         r_outBe    <= 4'd0;
         r_outLast  <= 1'b0;
      end else if (!w_stall) begin
         r_s1Valid <= w_accept;
         if (w_accept) begin
            r_s1Prod <= w_prod;
            r_s1Last <= acc_last;
            r_s1Sat  <= (acc_data == 32'h8000_0000) && (r_multiplier == 32'h8000_0000);
         end
         r_s2Valid <= r_s1Valid;
         if (r_s1Valid) begin
            r_s2X    <= w_x;
            r_s2Last <= r_s1Last;
         end
         r_outValid <= w_emit;
         if (w_emit) begin
            r_outData <= w_packNext;
            r_outBe   <= w_beNext;
            r_outLast <= r_s2Last;
            r_pack    <= 32'd0;
            r_lane    <= 2'd0;
         end else if (r_s2Valid) begin
            r_pack <= w_packNext;
            r_lane <= r_lane + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_requant_pack_unit.sv
// tb_requant_pack_unit
// Directed bench for requant_pack_unit. Each job is configured, streamed
// cycle by cycle, and its packed words, handshake timing and done pulse
// are compared against hand-computed values.

module tb_requant_pack_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] cfg_multiplier;
   logic [4:0]  cfg_shift;
   logic [7:0]  cfg_out_zp;
   logic [7:0]  cfg_act_min;
   logic [7:0]  cfg_act_max;
   logic        acc_valid;
   logic [31:0] acc_data;
   logic        acc_last;
   logic        acc_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic [3:0]  out_be;
   logic        out_last;
   logic        out_ready;
   logic        ready;
   logic        done;

   int          checks = 0;
   int          failures = 0;

   logic [31:0] accData [0:15];
   logic [31:0] wordData [0:7];
   logic [3:0]  wordBe [0:7];
   logic        wordLast [0:7];
   int          wordCount;
   int          doneCount;
   int          accStallSeen;
   int          unstableCount;
   int          firstValidCycle;
   int          lastAcceptCycle;
   int          lastHandshakeCycle;
   int          doneCycle;
   logic        readyAfterDone;
   int          accepted;
   int          resetDoneCount;

   requant_pack_unit dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .cfg_multiplier (cfg_multiplier),
      .cfg_shift      (cfg_shift),
      .cfg_out_zp     (cfg_out_zp),
      .cfg_act_min    (cfg_act_min),
      .cfg_act_max    (cfg_act_max),
      .acc_valid      (acc_valid),
      .acc_data       (acc_data),
      .acc_last       (acc_last),
      .acc_ready      (acc_ready),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_be         (out_be),
      .out_last       (out_last),
      .out_ready      (out_ready),
      .ready          (ready),
      .done           (done)
   );

   // 10-unit clock; inputs change and outputs are sampled around the falling edge.
   always #5 clk = ~clk;

   // One comparison: counts it, and on mismatch reports and counts the failure.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $display("[TB] FAIL %s: observed=0x%h expected=0x%h", tag, observed, expected);
         $error("[TB] %s observed=0x%h expected=0x%h", tag, observed, expected);
      end
   endtask

   // Pulses start with the given configuration and confirms the idle/run handover.
   task automatic startJob(input logic [31:0] m, input logic [4:0] sh, input logic [7:0] zp,
                           input logic [7:0] mn, input logic [7:0] mx);
      @(negedge clk);
      cfg_multiplier = m;
      cfg_shift      = sh;
      cfg_out_zp     = zp;
      cfg_act_min    = mn;
      cfg_act_max    = mx;
      out_ready      = 1'b1;
      start          = 1'b1;
      #1;
      checkOutput("idle_ready", 32'(ready), 32'd1);
      @(negedge clk);
      start = 1'b0;
      #1;
      checkOutput("run_ready_low", 32'(ready), 32'd0);
      checkOutput("run_acc_ready", 32'(acc_ready), 32'd1);
   endtask

   // Streams accData[0..n-1] and collects output words until done plus a
   // few cycles. holdCycles>0 holds out_ready low that many cycles once the
   // first word appears.
   task automatic applyStimulus(input int n, input int holdCycles);
      int          idx;
      int          cyc;
      int          holdLeft;
      bit          holdUsed;
      int          afterDone;
      bit          prevDone;
      logic [31:0] heldData;
      logic [3:0]  heldBe;
      logic        heldLast;
      idx = 0; cyc = 0; holdLeft = 0; holdUsed = 0; afterDone = 0; prevDone = 0;
      heldData = 32'd0; heldBe = 4'd0; heldLast = 1'b0;
      wordCount = 0; doneCount = 0; accStallSeen = 0; unstableCount = 0;
      firstValidCycle = -1; lastAcceptCycle = -1; lastHandshakeCycle = -1;
      doneCycle = -1; readyAfterDone = 1'b0;
      while (cyc < 400 && !(doneCount > 0 && afterDone >= 3)) begin
         if (!holdUsed && holdCycles > 0 && out_valid) begin
            holdUsed = 1;
            holdLeft = holdCycles;
            heldData = out_data;
            heldBe   = out_be;
            heldLast = out_last;
         end
         out_ready = (holdLeft == 0);
         if (holdLeft > 0) begin
            if (!out_valid || out_data !== heldData || out_be !== heldBe || out_last !== heldLast)
               unstableCount++;
            holdLeft--;
         end
         acc_valid = (idx < n);
         acc_data  = (idx < n) ? accData[idx] : 32'd0;
         acc_last  = (idx == n - 1);
         #1;
         if (prevDone) readyAfterDone = ready;
         prevDone = done;
         if (out_valid && firstValidCycle < 0) firstValidCycle = cyc;
         if (done) begin
            doneCount++;
            if (doneCycle < 0) doneCycle = cyc;
         end
         if (doneCount > 0) afterDone++;
         if (acc_valid && !acc_ready) accStallSeen++;
         if (acc_valid && acc_ready) begin
            lastAcceptCycle = cyc;
            idx++;
         end
         if (out_valid && out_ready) begin
            if (wordCount < 8) begin
               wordData[wordCount] = out_data;
               wordBe[wordCount]   = out_be;
               wordLast[wordCount] = out_last;
            end
            wordCount++;
            lastHandshakeCycle = cyc;
         end
         @(negedge clk);
         cyc++;
      end
      acc_valid = 1'b0;
      acc_last  = 1'b0;
      out_ready = 1'b1;
      checkOutput("job_completed", 32'(doneCount > 0), 32'd1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      cfg_multiplier = 32'd0; cfg_shift = 5'd0; cfg_out_zp = 8'd0;
      cfg_act_min = 8'h80; cfg_act_max = 8'h7F;
      acc_valid = 1'b0; acc_data = 32'd0; acc_last = 1'b0; out_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_ready", 32'(ready), 32'd1);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_acc_ready", 32'(acc_ready), 32'd0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data", out_data, 32'd0);
      checkOutput("rst_out_be", 32'(out_be), 32'd0);
      checkOutput("rst_out_last", 32'(out_last), 32'd0);
      rst = 1'b0;

      // Test 1: M=0.5, shift 1, zp 3. 400->103 (0x67), 0->3, -400->-97 (0x9F), 8->5
      startJob(32'h4000_0000, 5'd1, 8'd3, 8'h80, 8'h7F);
      accData[0] = 32'd400; accData[1] = 32'd0; accData[2] = -32'sd400; accData[3] = 32'd8;
      applyStimulus(4, 0);
      checkOutput("t1_words", 32'(wordCount), 32'd1);
      checkOutput("t1_data", wordData[0], 32'h059F_0367);
      checkOutput("t1_be", 32'(wordBe[0]), 32'hF);
      checkOutput("t1_last", 32'(wordLast[0]), 32'd1);
      checkOutput("t1_latency", 32'(firstValidCycle - lastAcceptCycle), 32'd3);
      checkOutput("t1_done_timing", 32'(doneCycle - lastHandshakeCycle), 32'd1);
      checkOutput("t1_done_once", 32'(doneCount), 32'd1);
      checkOutput("t1_ready_after_done", 32'(readyAfterDone), 32'd1);

      // Test 2: clamp to +127 and -128, partial word of two bytes
      startJob(32'h4000_0000, 5'd1, 8'd3, 8'h80, 8'h7F);
      accData[0] = 32'd100000; accData[1] = -32'sd100000;
      applyStimulus(2, 0);
      checkOutput("t2_words", 32'(wordCount), 32'd1);
      checkOutput("t2_data", wordData[0], 32'h0000_807F);
      checkOutput("t2_be", 32'(wordBe[0]), 32'h3);
      checkOutput("t2_last", 32'(wordLast[0]), 32'd1);

      // Test 3: rounding ties away from zero; 6->2, -6->-2, 5->1, 2->1
      startJob(32'h7FFF_FFFF, 5'd2, 8'd0, 8'h80, 8'h7F);
      accData[0] = 32'd6; accData[1] = -32'sd6; accData[2] = 32'd5; accData[3] = 32'd2;
      applyStimulus(4, 0);
      checkOutput("t3_data", wordData[0], 32'h0101_FE02);
      checkOutput("t3_be", 32'(wordBe[0]), 32'hF);

      // Test 4: saturating multiply, 0x7FFFFFFF >> 24 rounds to 128, clamps to 127
      startJob(32'h8000_0000, 5'd24, 8'd0, 8'h80, 8'h7F);
      accData[0] = 32'h8000_0000;
      applyStimulus(1, 0);
      checkOutput("t4_words", 32'(wordCount), 32'd1);
      checkOutput("t4_data", wordData[0], 32'h0000_007F);
      checkOutput("t4_be", 32'(wordBe[0]), 32'h1);
      checkOutput("t4_last", 32'(wordLast[0]), 32'd1);
      checkOutput("t4_latency", 32'(firstValidCycle - lastAcceptCycle), 32'd3);

      // Test 5: acc 4*i maps to byte i+3; output held for 10 cycles
      startJob(32'h4000_0000, 5'd1, 8'd3, 8'h80, 8'h7F);
      for (int i = 0; i < 12; i++) accData[i] = 32'(4 * i);
      applyStimulus(12, 10);
      checkOutput("t5_words", 32'(wordCount), 32'd3);
      checkOutput("t5_word0", wordData[0], 32'h0605_0403);
      checkOutput("t5_word1", wordData[1], 32'h0A09_0807);
      checkOutput("t5_word2", wordData[2], 32'h0E0D_0C0B);
      checkOutput("t5_be2", 32'(wordBe[2]), 32'hF);
      checkOutput("t5_last0", 32'(wordLast[0]), 32'd0);
      checkOutput("t5_last1", 32'(wordLast[1]), 32'd0);
      checkOutput("t5_last2", 32'(wordLast[2]), 32'd1);
      checkOutput("t5_acc_ready_dropped", 32'(accStallSeen > 0), 32'd1);
      checkOutput("t5_held_stable", 32'(unstableCount), 32'd0);
      checkOutput("t5_done_once", 32'(doneCount), 32'd1);

      // Test 6: reset after five accepted elements with a word held at the output
      startJob(32'h4000_0000, 5'd1, 8'd3, 8'h80, 8'h7F);
      accepted = 0;
      for (int c = 0; c < 20 && accepted < 5; c++) begin
         out_ready = 1'b0;
         acc_valid = 1'b1;
         acc_data  = 32'(4 * accepted);
         acc_last  = 1'b0;
         #1;
         if (acc_ready) accepted++;
         @(negedge clk);
      end
      acc_valid = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("t6_accepted", 32'(accepted), 32'd5);
      checkOutput("t6_pre_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("t6_rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("t6_rst_ready", 32'(ready), 32'd1);
      checkOutput("t6_rst_acc_ready", 32'(acc_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      resetDoneCount = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (done) resetDoneCount++;
      end
      checkOutput("t6_no_done", 32'(resetDoneCount), 32'd0);
      startJob(32'h4000_0000, 5'd1, 8'd3, 8'h80, 8'h7F);
      accData[0] = 32'd8;
      applyStimulus(1, 0);
      checkOutput("t6_new_data", wordData[0], 32'h0000_0005);
      checkOutput("t6_new_be", 32'(wordBe[0]), 32'h1);
      checkOutput("t6_new_last", 32'(wordLast[0]), 32'd1);
      checkOutput("t6_new_done", 32'(doneCount), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
